ibex_instr_bus_responder: RTL and testbench
===========================================

// Module: ibex_instr_bus_responder
// PURPOSE
//  Responder end of the core instruction-fetch bus (req/gnt/rvalid/rdata/err). Serves fetch requests
//  from a single-port synchronous instruction memory (1-cycle read latency) behind it.
//  Returns responses in order, after a fixed latency; supports multiple outstanding requests.
//  Used as the fetch-side memory in core-level simulation and FPGA top levels.
// PARAMETERS
//  MemBase        32'h0000_0000  byte base address of the memory window
//  MemSizeBytes   65536          window size in bytes; power of two, >=4
//  RespLatency    1              cycles from grant cycle to rvalid cycle; 1..4
//  MaxOutstanding 2              max granted-but-unanswered requests; 1..4
//  GntStallPeriod 0              0: no stalls; P>0: gnt forced low 1 cycle after every P-th grant
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   reset, asynchronous, active-low
//  instr_req_i     in   1   fetch request valid
//  instr_addr_i    in   32  fetch byte address
//  instr_gnt_o     out  1   request accepted this cycle (combinational from instr_req_i + state)
//  instr_rvalid_o  out  1   response valid
//  instr_rdata_o   out  32  response data; 0 when instr_err_o=1
//  instr_err_o     out  1   bus error; only asserted with instr_rvalid_o
//  mem_req_o       out  1   memory read strobe
//  mem_addr_o      out  AW  word address, AW=$clog2(MemSizeBytes/4)
//  mem_rdata_i     in   32  memory data, valid in the cycle after mem_req_o
//  outstanding_o   out  3   current in-flight count (debug/coverage)
// BEHAVIOUR
//  Reset: instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0, mem_req_o=0, outstanding_o=0;
//   pipeline, stall counter and stall flag cleared. Reset mid-operation drops every in-flight
//   response; none are emitted after reset release.
//  Grant: instr_gnt_o = instr_req_i & ~stall_q & (cnt_q < MaxOutstanding | instr_rvalid_o).
//   A response retiring in the same cycle frees its slot for the new grant.
//  Decode on grant: off = instr_addr_i - MemBase (32-bit wrap). The request is an error if
//   off >= MemSizeBytes or instr_addr_i[1:0]!=0. Legal: mem_req_o=1, mem_addr_o=off[AW+1:2].
//   Error: mem_req_o=0, mem_addr_o=0. mem_req_o is never asserted without instr_gnt_o.
//  Response pipe: RespLatency stages of {valid, err, data}. Stage 1 is loaded on every cycle:
//   valid=instr_gnt_o, err=decode error. The response is in stage k in cycle k after the grant
//   (k=1..RespLatency). Data is taken from mem_rdata_i in the stage-1 cycle: it drives
//   instr_rdata_o directly when RespLatency=1, and is registered into stage 2 otherwise.
//  instr_rvalid_o = valid of last stage. rdata is forced 0 on error. There is no rvalid
//   backpressure; responses are strictly in grant order.
//  cnt_q: +1 on grant, -1 on rvalid, unchanged if both occur. Never exceeds MaxOutstanding.
//   Never underflows; rvalid with cnt_q==0 is impossible by construction.
//  Stall: when GntStallPeriod>0, a mod-P counter increments on each grant. A grant that wraps it
//   (value P-1 -> 0) sets stall_q for exactly the next cycle. Stall gating is suppressed when P=0.
//  Request held low or address changes while not granted: no state change. The requester may
//   drop the request without penalty.
//  Simultaneous grant + retire + stall-wrap in one cycle are all honoured independently.
// TESTING
//  T1 L=1: req addr 0x100, mem word 0x40=0xDEADBEEF -> gnt same cycle, mem_addr=0x40;
//     next cycle rvalid=1, rdata=0xDEADBEEF, err=0.
//  T2 L=1, Max=2: req held 8 cycles to 0x0,0x4,..,0x1C -> gnt every cycle;
//     8 rvalids in order, 1 cycle later each.
//  T3 addr MemBase+MemSizeBytes and addr 0x102 -> gnt=1, mem_req=0;
//     rvalid with err=1, rdata=0; cnt returns to 0.
//  T4 L=3, Max=2: continuous req -> gnt pattern 1,1,0,1,1,0...; outstanding_o never exceeds 2.
//  T5 P=3, L=1: continuous req -> gnt low one cycle after every 3rd grant
//     (1,1,1,0,1,1,1,0); data ordering intact.
//  T6 L=3: 2 grants issued, rst_ni pulsed low before first rvalid -> no rvalid after release;
//     outstanding_o=0; the next request completes normally.

Source files
------------

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus responder in front of a 1-cycle synchronous memory.
// In-order responses after a fixed latency, bounded outstanding count, optional grant stalls.
module ibex_instr_bus_responder #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int          MemSizeBytes   = 65536,
    parameter int          RespLatency    = 1,
    parameter int          MaxOutstanding = 2,
    parameter int          GntStallPeriod = 0,
    localparam int         AW             = $clog2(MemSizeBytes / 4)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i,
    output logic [2:0]    outstanding_o
);

    localparam int SW = (GntStallPeriod > 1) ? $clog2(GntStallPeriod) : 1;

    logic [31:0]          off;
    logic                 dec_err;
    logic [2:0]           cnt_q;
    logic                 stall_q;
    logic [SW-1:0]        st_cnt_q;
    logic                 st_wrap;
    logic [RespLatency-1:0] v_q;
    logic [RespLatency-1:0] e_q;
    logic [31:0]          data_last;

    // Address decode and grant gating (a retiring response frees its slot)
    always_comb begin
        off         = instr_addr_i - MemBase;
        dec_err     = (off >= 32'(MemSizeBytes)) | (|instr_addr_i[1:0]);
        instr_gnt_o = instr_req_i & ~stall_q
                    & ((cnt_q < 3'(MaxOutstanding)) | instr_rvalid_o);
        mem_req_o   = instr_gnt_o & ~dec_err;
        mem_addr_o  = mem_req_o ? off[AW+1:2] : '0;
        st_wrap     = (st_cnt_q == SW'(GntStallPeriod - 1));
    end

    // Response valid/err pipeline: stage 1 loaded every cycle from the grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            e_q <= '0;
        end else begin
            v_q[0] <= instr_gnt_o;
            e_q[0] <= instr_gnt_o & dec_err;
            for (int k = 1; k < RespLatency; k++) begin
                v_q[k] <= v_q[k-1];
                e_q[k] <= e_q[k-1];
            end
        end
    end

    // Read data: direct from memory for latency 1, otherwise carried in stages 2..L
    if (RespLatency == 1) begin : g_direct
        assign data_last = mem_rdata_i;
    end else begin : g_reg
        logic [31:0] d_q [RespLatency-1:1];

        // Capture memory data in the stage-1 cycle and shift toward the output
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 1; k < RespLatency; k++) begin
                    d_q[k] <= '0;
                end
            end else begin
                d_q[1] <= mem_rdata_i;
                for (int k = 2; k < RespLatency; k++) begin
                    d_q[k] <= d_q[k-1];
                end
            end
        end

        assign data_last = d_q[RespLatency-1];
    end

    assign instr_rvalid_o = v_q[RespLatency-1];
    assign instr_err_o    = v_q[RespLatency-1] & e_q[RespLatency-1];
    assign instr_rdata_o  = (instr_rvalid_o & ~instr_err_o) ? data_last : '0;
    assign outstanding_o  = cnt_q;

    // In-flight counter: grant adds, retire removes, both together cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            unique case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Grant stall: mod-P grant counter, wrap blocks the grant for one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_cnt_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            stall_q <= (GntStallPeriod > 0) & instr_gnt_o & st_wrap;
            if (instr_gnt_o) begin
                st_cnt_q <= st_wrap ? '0 : st_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed bench for ibex_instr_bus_responder: three instances cover
// latency 1, latency 3 and the grant-stall configuration.
module tb_ibex_instr_bus_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // u0: L=1 Max=2 P=0
    logic        req0 = 0, gnt0, rv0, err0, mreq0;
    logic [31:0] addr0 = 0, rd0, mrd0 = 0;
    logic [13:0] maddr0;
    logic [2:0]  out0;
    // u1: L=3 Max=2 P=0
    logic        req1 = 0, gnt1, rv1, err1, mreq1;
    logic [31:0] addr1 = 0, rd1, mrd1 = 0;
    logic [13:0] maddr1;
    logic [2:0]  out1;
    // u2: L=1 Max=2 P=3
    logic        req2 = 0, gnt2, rv2, err2, mreq2;
    logic [31:0] addr2 = 0, rd2, mrd2 = 0;
    logic [13:0] maddr2;
    logic [2:0]  out2;

    ibex_instr_bus_responder u0 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req0), .instr_addr_i(addr0),
        .instr_gnt_o(gnt0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0),
        .instr_err_o(err0), .mem_req_o(mreq0), .mem_addr_o(maddr0),
        .mem_rdata_i(mrd0), .outstanding_o(out0)
    );

    ibex_instr_bus_responder #(.RespLatency(3), .MaxOutstanding(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req1), .instr_addr_i(addr1),
        .instr_gnt_o(gnt1), .instr_rvalid_o(rv1), .instr_rdata_o(rd1),
        .instr_err_o(err1), .mem_req_o(mreq1), .mem_addr_o(maddr1),
        .mem_rdata_i(mrd1), .outstanding_o(out1)
    );

    ibex_instr_bus_responder #(.RespLatency(1), .GntStallPeriod(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req2), .instr_addr_i(addr2),
        .instr_gnt_o(gnt2), .instr_rvalid_o(rv2), .instr_rdata_o(rd2),
        .instr_err_o(err2), .mem_req_o(mreq2), .mem_addr_o(maddr2),
        .mem_rdata_i(mrd2), .outstanding_o(out2)
    );

    function automatic logic [31:0] memval(input logic [31:0] w);
        return (w == 32'h40) ? 32'hDEAD_BEEF : 32'h1000_0000 + w;
    endfunction

    // Synchronous memories with one-cycle read latency
    always @(posedge clk) begin
        if (mreq0) mrd0 <= memval({18'b0, maddr0});
        if (mreq1) mrd1 <= memval({18'b0, maddr1});
        if (mreq2) mrd2 <= memval({18'b0, maddr2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] e;
        logic [8:0]  pat4;
        logic [7:0]  pat5;
        int          k;

        pat4 = 9'b011_011_011;
        pat5 = 8'b0111_0111;

        // Reset state
        tick();
        tick();
        chk("rst_rvalid", rv0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rdata", rd0, 0);
        chk("rst_memreq", mreq0, 0);
        chk("rst_out", out0, 0);
        rst_n = 1'b1;
        tick();

        // T1: single fetch
        req0 = 1; addr0 = 32'h100;
        #1;
        chk("t1_gnt", gnt0, 1);
        chk("t1_memreq", mreq0, 1);
        chk("t1_memaddr", maddr0, 32'h40);
        tick();
        req0 = 0;
        #1;
        chk("t1_rvalid", rv0, 1);
        chk("t1_rdata", rd0, 32'hDEAD_BEEF);
        chk("t1_err", err0, 0);
        chk("t1_out", out0, 1);
        tick();
        chk("t1_rvalid_done", rv0, 0);
        chk("t1_out_done", out0, 0);

        // T2: back-to-back fetches, one grant per cycle
        for (int i = 0; i < 8; i++) begin
            req0 = 1; addr0 = 32'(4 * i);
            #1;
            chk($sformatf("t2_gnt%0d", i), gnt0, 1);
            if (i > 0) begin
                chk($sformatf("t2_rv%0d", i), rv0, 1);
                chk($sformatf("t2_rd%0d", i), rd0, memval(32'(i - 1)));
            end
            tick();
        end
        req0 = 0;
        #1;
        chk("t2_rv_last", rv0, 1);
        chk("t2_rd_last", rd0, memval(7));
        tick();
        chk("t2_out_done", out0, 0);

        // T3: out-of-window and misaligned addresses
        req0 = 1; addr0 = 32'h0001_0000;
        #1;
        chk("t3a_gnt", gnt0, 1);
        chk("t3a_memreq", mreq0, 0);
        chk("t3a_memaddr", maddr0, 0);
        tick();
        addr0 = 32'h102;
        #1;
        chk("t3b_gnt", gnt0, 1);
        chk("t3b_memreq", mreq0, 0);
        chk("t3a_rv", rv0, 1);
        chk("t3a_err", err0, 1);
        chk("t3a_rd", rd0, 0);
        tick();
        req0 = 0;
        #1;
        chk("t3b_rv", rv0, 1);
        chk("t3b_err", err0, 1);
        chk("t3b_rd", rd0, 0);
        tick();
        chk("t3_out_done", out0, 0);
        chk("t3_err_done", err0, 0);

        // T4: L=3, Max=2 continuous request
        k = 0;
        for (int c = 0; c < 9; c++) begin
            req1 = 1; addr1 = 32'(4 * k);
            #1;
            chk($sformatf("t4_gnt%0d", c), gnt1, pat4[c]);
            chk("t4_out_le2", out1 <= 3'd2, 1);
            if (rv1) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                chk("t4_data", rd1, e);
            end
            if (gnt1) begin
                q.push_back(memval(32'(k)));
                k++;
            end
            tick();
        end
        req1 = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (rv1) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                chk("t4_drain_data", rd1, e);
            end
            tick();
        end
        chk("t4_all_retired", q.size(), 0);
        chk("t4_out_done", out1, 0);

        // T5: P=3 grant stall
        k = 0;
        for (int c = 0; c < 8; c++) begin
            req2 = 1; addr2 = 32'(4 * k);
            #1;
            chk($sformatf("t5_gnt%0d", c), gnt2, pat5[c]);
            if (rv2) begin
                e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
                chk("t5_data", rd2, e);
            end
            if (gnt2) begin
                q.push_back(memval(32'(k)));
                k++;
            end
            tick();
        end
        req2 = 0;
        #1;
        if (rv2) begin
            e = (q.size() > 0) ? q.pop_front() : 32'hFFFF_FFFF;
            chk("t5_data_last", rd2, e);
        end
        tick();
        chk("t5_all_retired", q.size(), 0);
        chk("t5_out_done", out2, 0);

        // T6: reset while two L=3 responses are in flight
        req1 = 1; addr1 = 32'h20;
        #1;
        chk("t6_gnt0", gnt1, 1);
        tick();
        addr1 = 32'h24;
        #1;
        chk("t6_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        chk("t6_out_pre", out1, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_out_rst", out1, 0);
        chk("t6_rv_rst", rv1, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t6_no_rv%0d", c), rv1, 0);
            tick();
        end
        chk("t6_out_idle", out1, 0);
        req1 = 1; addr1 = 32'h28;
        #1;
        chk("t6_gnt_new", gnt1, 1);
        tick();
        req1 = 0;
        tick();
        tick();
        chk("t6_rv_new", rv1, 1);
        chk("t6_rd_new", rd1, memval(32'h0A));
        chk("t6_err_new", err1, 0);
        tick();
        chk("t6_out_done", out1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
